// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido core: opcode classes, sequencer states,
// instruction kinds and fault codes.
package lapido_pkg;

  localparam logic [2:0] CLS_ALU   = 3'b001;
  localparam logic [2:0] CLS_MEM   = 3'b100;
  localparam logic [2:0] CLS_CONST = 3'b010;
  localparam logic [2:0] CLS_NOP   = 3'b000;

  localparam logic [1:0] SUB_LOADLIT = 2'b10;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_OPCODE = 2'b01;
  localparam logic [1:0] FC_IMEM   = 2'b10;
  localparam logic [1:0] FC_DMEM   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_LIT, K_LOAD, K_STORE, K_UNKNOWN
  } kind_t;

  // Constant-class words other than loadlit behave as NOPs.
  function automatic kind_t decode_kind(input logic [31:0] instr);
    kind_t k;
    case (instr[31:29])
      CLS_ALU:   k = K_ALU;
      CLS_MEM:   k = instr[24] ? K_STORE : K_LOAD;
      CLS_CONST: k = (instr[25:24] == SUB_LOADLIT) ? K_LIT : K_NOP;
      CLS_NOP:   k = K_NOP;
      default:   k = K_UNKNOWN;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready wait cycles; expired flags the cycle where the
// wait reaches MEM_TIMEOUT and ready is still low. MEM_TIMEOUT = 0 disables it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic expired
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [TW-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (waiting && !ready) begin
      count_reg <= count_reg + TW'(1);
    end
  end

  // count_reg holds the number of earlier low cycles, so this cycle is wait number count_reg+1.
  assign expired = (MEM_TIMEOUT != 0) && waiting && !ready &&
                   (count_reg == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the Lapido
// core: drives the fetch, IR, PC, register-file and data-memory strobes.
module instr_sequencer
  import lapido_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [31:0]      instruction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             pc_enable,
  output logic             mem_read_n,
  output logic             mem_write_n,
  output logic             reg_write,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  state_t           state_reg, state_next;
  kind_t            kind_reg, kind_next;
  kind_t            dec_kind;
  logic             fault_reg, fault_next;
  logic [1:0]       fault_code_reg, fault_code_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;
  logic             in_fetch, in_memory;
  logic             waiting, ready_sel, expired, timer_clear;
  logic             unused_instr_bits;

  assign dec_kind          = decode_kind(instruction);
  assign unused_instr_bits = ^{instruction[28:26], instruction[23:0]};

  assign in_fetch    = (state_reg == ST_FETCH);
  assign in_memory   = (state_reg == ST_MEMORY);
  assign waiting     = in_fetch || in_memory;
  assign ready_sel   = in_fetch ? imem_ready : dmem_ready;
  // Any state change restarts the wait count, so each wait is measured from its own entry.
  assign timer_clear = (state_next != state_reg);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .waiting (waiting),
    .ready   (ready_sel),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      kind_reg       <= K_NOP;
      fault_reg      <= 1'b0;
      fault_code_reg <= FC_NONE;
      retired_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      kind_reg       <= kind_next;
      fault_reg      <= fault_next;
      fault_code_reg <= fault_code_next;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next      = state_reg;
    kind_next       = kind_reg;
    fault_next      = fault_reg;
    fault_code_next = fault_code_reg;
    retire          = 1'b0;
    case (state_reg)
      ST_IDLE: if (run) state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_next = ST_DECODE;
        end else if (expired) begin
          state_next      = ST_HALT;
          fault_next      = 1'b1;
          fault_code_next = FC_IMEM;
        end
      end
      ST_DECODE: begin
        kind_next = dec_kind;
        case (dec_kind)
          K_NOP: begin
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
          end
          K_UNKNOWN: begin
            state_next      = ST_HALT;
            fault_next      = 1'b1;
            fault_code_next = FC_OPCODE;
          end
          default: state_next = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE:
        state_next = (kind_reg == K_LOAD || kind_reg == K_STORE) ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY: begin
        if (dmem_ready) begin
          if (kind_reg == K_STORE) begin
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
          end else begin
            state_next = ST_WRITEBACK;
          end
        end else if (expired) begin
          state_next      = ST_HALT;
          fault_next      = 1'b1;
          fault_code_next = FC_DMEM;
        end
      end
      ST_WRITEBACK: begin
        retire     = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  assign fetch_req   = in_fetch;
  assign ir_load     = in_fetch && imem_ready;
  assign pc_enable   = in_fetch && imem_ready;
  assign mem_read_n  = !(in_memory && kind_reg == K_LOAD);
  assign mem_write_n = !(in_memory && kind_reg == K_STORE);
  assign reg_write   = (state_reg == ST_WRITEBACK);
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
  assign fault       = fault_reg;
  assign fault_code  = fault_code_reg;
  assign retired     = retired_reg;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the Lapido core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and drives the PC enable, IR load, register-file write strobe and active-low data-memory strobes. It waits on ready handshakes from instruction and data memory, and halts with a fault code on an unknown opcode class or a memory timeout. It sits beside `control`, which supplies ALUOp/ALUSrc/memToReg; this block supplies the timing.

## Interface

- `MEM_TIMEOUT`, 15: maximum consecutive wait cycles on a ready; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = keep issuing instructions
- `instruction`  in  32  IR output, stable from the cycle after `ir_load`
- `imem_ready`  in  1  instruction word valid this cycle
- `dmem_ready`  in  1  data access completes this cycle
- `fetch_req`  out  1  instruction fetch request
- `ir_load`  out  1  IR capture pulse
- `pc_enable`  out  1  PC increment pulse
- `mem_read_n`  out  1  data read strobe, active-low
- `mem_write_n`  out  1  data write strobe, active-low
- `reg_write`  out  1  register-file write pulse
- `busy`  out  1  state is not IDLE and not HALT
- `fault`  out  1  sticky error flag
- `fault_code`  out  2  00 none, 01 unknown opcode, 10 imem timeout, 11 dmem timeout
- `retired`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W

## Operation

- Opcode class is `instruction[31:29]`:
  - 001: ALU
  - 100: memory; `[24]` 0 = load, 1 = store
  - 010: constant; `[25:24]` = 10 is loadlit, any other value is treated as NOP
  - 000: NOP
  - any other value: unknown
- States and transitions:
  - IDLE: go to FETCH when `run` = 1.
  - FETCH: `fetch_req` = 1. On `imem_ready`, pulse `ir_load` and `pc_enable`, then go to DECODE.
  - DECODE: latch the instruction kind.
    - ALU, loadlit, load or store: go to EXECUTE.
    - NOP: retire.
    - Unknown: go to HALT with code 01.
  - EXECUTE: one cycle. ALU and loadlit go to WRITEBACK; load and store go to MEMORY.
  - MEMORY: load holds `mem_read_n` = 0 and store holds `mem_write_n` = 0 until `dmem_ready`. On ready, a load goes to WRITEBACK and a store retires.
  - WRITEBACK: `reg_write` = 1 for one cycle, then retire.
  - Retire: increment `retired`, then go to FETCH if `run` = 1, otherwise IDLE.
  - HALT: absorbing; only reset exits. All strobes are inactive.
- Timeout counter:
  - Counts consecutive cycles in FETCH or MEMORY with ready low; clears on every state entry.
  - Fault fires when ready is still low on wait cycle `MEM_TIMEOUT`. A ready arriving in that same cycle wins.
  - Fault sets `fault`, loads `fault_code`, and goes to HALT.
- `run` dropping mid-instruction: the current instruction completes, then the block goes to IDLE.

## Timing

- Reset values: state IDLE, `fetch_req` 0, `ir_load` 0, `pc_enable` 0, `mem_read_n` 1, `mem_write_n` 1, `reg_write` 0, `busy` 0, `fault` 0, `fault_code` 00, `retired` 0, timeout counter 0.
- Output decoding:
  - Strobes decode from registered state.
  - `ir_load` and `pc_enable` equal `(state == FETCH) & imem_ready`, a combinational path from the input.
  - `retired` updates at the clock edge that ends the retiring cycle.
- Latency with zero-wait memories, counted from entry to FETCH:
  - NOP: 2 cycles
  - ALU and loadlit: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each memory wait cycle adds 1.
- Back-to-back operation: with `run` held, FETCH of the next instruction follows the retiring cycle directly, with no bubble.
- Reset asserted mid-instruction: all outputs return to reset values immediately, asynchronously. Any strobe in progress is dropped.

## Structure

- `lapido_pkg` holds:
  - opcode class constants (`CLS_ALU`, `CLS_MEM`, `CLS_CONST`, `CLS_NOP`)
  - the loadlit subcode
  - the state enum
  - the fault-code constants
- `control` imports the same class constants.
- Sub-module `mem_wait_timer`: parameterised by `MEM_TIMEOUT`; inputs clear, waiting, ready; output expired.

## Test plan

- ALU word 0x20000000 with `imem_ready` held high and `run` = 1 -> `reg_write` pulses in cycle 4, `retired` = 1, next FETCH in cycle 5.
- Load 0x80000000 with `dmem_ready` delayed 3 cycles -> `mem_read_n` low for exactly 4 cycles, then a `reg_write` pulse; total 8 cycles.
- Store 0x81000000 -> `mem_write_n` low 1 cycle, `reg_write` never high, `retired` increments at the MEMORY exit.
- Word 0xE0000000 -> HALT, `fault` = 1, `fault_code` = 01, `busy` = 0; stays there until `reset_n` is pulsed.
- `imem_ready` held low with `MEM_TIMEOUT` = 15 -> fault code 10 after 15 wait cycles. A second run with ready rising on cycle 15 -> no fault.
- `reset_n` asserted during MEMORY of a store -> `mem_write_n` = 1 and `retired` = 0 immediately; FETCH restarts after release with `run` = 1.
